// File: rtl/led_pattern_ctrl.sv
// led_pattern_ctrl: board-level LED demo engine for DE0-Nano.
// Keys are synchronised and debounced into one-cycle press events.
// Switches are synchronised and select one of four animated patterns.
// A prescaler sets the pattern step rate, which the keys can pause or
// slow down in power-of-two steps.
//
// Output protocol: KEY_EVT[i] is a strobe with no back-pressure. It is
// high for exactly one clock per debounced press, and every consumer
// must act in that cycle. LED and MODE are plain registered levels.
module led_pattern_ctrl #(
  parameter int CLK_HZ      = 50_000_000,
  parameter int N_LED       = 8,
  parameter int DEBOUNCE_MS = 10,
  parameter int STEP_HZ     = 4
) (
  input  logic             CLOCK_50,
  input  logic             RST_N,
  input  logic [1:0]       KEY,
  input  logic [3:0]       SW,
  output logic [N_LED-1:0] LED,
  output logic [1:0]       KEY_EVT,
  output logic [1:0]       MODE
);

  // Debounce window in cycles, never below one.
  localparam int DB_RAW   = (CLK_HZ / 1000) * DEBOUNCE_MS;
  localparam int DB_CYC   = (DB_RAW < 1) ? 1 : DB_RAW;
  localparam int DB_W     = $clog2(DB_CYC + 1);

  // Base step period in cycles, never below two.
  // The prescaler must reach 8*STEP_CYC-1 at the slowest speed.
  localparam int STEP_RAW = CLK_HZ / STEP_HZ;
  localparam int STEP_CYC = (STEP_RAW < 2) ? 2 : STEP_RAW;
  localparam int PS_W     = $clog2(STEP_CYC * 8);

  localparam logic [N_LED-1:0] PAT_ONE = N_LED'(1);

  // Bounce direction. It is a small two-state machine that moves only
  // in mode 2.
  typedef enum logic {
    DIR_LEFT  = 1'b0,
    DIR_RIGHT = 1'b1
  } dir_t;

  // ------------------------------------------------------------------
  // Input synchronisers
  // ------------------------------------------------------------------
  logic [1:0] r_key_s1;
  logic [1:0] r_key_s2;
  logic [3:0] r_sw_s1;
  logic [3:0] r_sw_s2;

  // Two-flop synchronisers. Keys idle high (released), switches idle low.
  always_ff @(posedge CLOCK_50) begin
    if (!RST_N) begin
      r_key_s1 <= 2'b11;
      r_key_s2 <= 2'b11;
      r_sw_s1  <= 4'b0000;
      r_sw_s2  <= 4'b0000;
    end else begin
      r_key_s1 <= KEY;
      r_key_s2 <= r_key_s1;
      r_sw_s1  <= SW;
      r_sw_s2  <= r_sw_s1;
    end
  end

  // ------------------------------------------------------------------
  // Per-key debounce and press-event generation
  // ------------------------------------------------------------------
  logic [1:0] w_key_evt;

  for (genvar gi = 0; gi < 2; gi++) begin : g_db
    logic            r_stable;
    logic [DB_W-1:0] r_cnt;
    logic            r_evt;
    logic            w_differs;
    logic            w_settled;

    // The synchronised level must disagree with the stable level for
    // DB_CYC+1 consecutive samples before the stable level follows it.
    assign w_differs = (r_key_s2[gi] != r_stable);
    assign w_settled = w_differs && (r_cnt == DB_W'(DB_CYC));

    // Stable level, agreement counter, and a registered pulse on a
    // stable high-to-low (press) transition.
    always_ff @(posedge CLOCK_50) begin
      if (!RST_N) begin
        r_stable <= 1'b1;
        r_cnt    <= '0;
        r_evt    <= 1'b0;
      end else begin
        r_evt <= w_settled && r_stable;
        if (w_settled) begin
          r_stable <= r_key_s2[gi];
          r_cnt    <= '0;
        end else if (w_differs) begin
          r_cnt <= r_cnt + DB_W'(1);
        end else begin
          r_cnt <= '0;
        end
      end
    end

    assign w_key_evt[gi] = r_evt;
  end

  // ------------------------------------------------------------------
  // Pattern engine state
  // ------------------------------------------------------------------
  logic [1:0]       r_mode;
  logic [1:0]       w_mode_next;
  logic [N_LED-1:0] r_pattern;
  logic [N_LED-1:0] w_pattern_next;
  logic [N_LED-1:0] w_step_pattern;
  logic [N_LED-1:0] w_init_pattern;
  dir_t             r_dir;
  dir_t             w_dir_next;
  dir_t             w_step_dir;
  logic [PS_W-1:0]  r_presc;
  logic [PS_W-1:0]  w_presc_next;
  logic [PS_W-1:0]  w_presc_term;
  logic             r_paused;
  logic             w_paused_next;
  logic [1:0]       r_speed;
  logic [1:0]       w_speed_next;
  logic             w_mode_chg;
  logic             w_tick;
  logic             w_rev;
  logic             w_en;

  assign w_rev      = r_sw_s2[2];
  assign w_en       = r_sw_s2[3];
  assign w_mode_chg = (r_sw_s2[1:0] != r_mode);
  assign w_tick     = !r_paused && (r_presc == w_presc_term);

  // Prescaler terminal value: each speed step doubles the period.
  always_comb begin
    w_presc_term = PS_W'(STEP_CYC - 1);
    case (r_speed)
      2'd0:    w_presc_term = PS_W'(STEP_CYC - 1);
      2'd1:    w_presc_term = PS_W'(STEP_CYC * 2 - 1);
      2'd2:    w_presc_term = PS_W'(STEP_CYC * 4 - 1);
      2'd3:    w_presc_term = PS_W'(STEP_CYC * 8 - 1);
      default: w_presc_term = PS_W'(STEP_CYC - 1);
    endcase
  end

  // Starting pattern of the mode being switched into.
  always_comb begin
    w_init_pattern = '0;
    case (r_sw_s2[1:0])
      2'd0:    w_init_pattern = '0;
      2'd1:    w_init_pattern = PAT_ONE;
      2'd2:    w_init_pattern = PAT_ONE;
      default: w_init_pattern = '1;
    endcase
  end

  // One step of the current mode's animation, and the bounce direction
  // that follows it. The bounce direction turns on the step that lands
  // on an end bit, so each end position is shown for exactly one step.
  always_comb begin
    w_step_pattern = r_pattern;
    w_step_dir     = r_dir;
    case (r_mode)
      2'd0: begin
        if (w_rev) w_step_pattern = r_pattern - PAT_ONE;
        else       w_step_pattern = r_pattern + PAT_ONE;
      end
      2'd1: begin
        if (w_rev) w_step_pattern = {r_pattern[0], r_pattern[N_LED-1:1]};
        else       w_step_pattern = {r_pattern[N_LED-2:0], r_pattern[N_LED-1]};
      end
      2'd2: begin
        if (r_dir == DIR_LEFT) begin
          w_step_pattern = r_pattern << 1;
          if (w_step_pattern[N_LED-1]) w_step_dir = DIR_RIGHT;
        end else begin
          w_step_pattern = r_pattern >> 1;
          if (w_step_pattern[0]) w_step_dir = DIR_LEFT;
        end
      end
      default: begin
        w_step_pattern = ~r_pattern;
      end
    endcase
  end

  // Next-state logic. A mode change wins over a coincident tick. Key
  // events always apply: the pause toggle takes effect after any tick
  // in the same cycle, and a speed step restarts the prescaler.
  always_comb begin
    w_mode_next    = r_mode;
    w_pattern_next = r_pattern;
    w_dir_next     = r_dir;
    w_presc_next   = r_presc;
    w_paused_next  = r_paused ^ w_key_evt[0];
    w_speed_next   = r_speed + {1'b0, w_key_evt[1]};
    if (w_mode_chg) begin
      w_mode_next    = r_sw_s2[1:0];
      w_pattern_next = w_init_pattern;
      w_dir_next     = DIR_LEFT;
      w_presc_next   = '0;
    end else begin
      if (w_tick) begin
        w_pattern_next = w_step_pattern;
        w_dir_next     = w_step_dir;
      end
      if (w_key_evt[1] || w_tick) begin
        w_presc_next = '0;
      end else if (!r_paused) begin
        w_presc_next = r_presc + PS_W'(1);
      end
    end
  end

  // Pattern engine state registers.
  always_ff @(posedge CLOCK_50) begin
    if (!RST_N) begin
      r_mode    <= 2'd0;
      r_pattern <= '0;
      r_dir     <= DIR_LEFT;
      r_presc   <= '0;
      r_paused  <= 1'b0;
      r_speed   <= 2'd0;
    end else begin
      r_mode    <= w_mode_next;
      r_pattern <= w_pattern_next;
      r_dir     <= w_dir_next;
      r_presc   <= w_presc_next;
      r_paused  <= w_paused_next;
      r_speed   <= w_speed_next;
    end
  end

  // LED enable gates the output only. The pattern keeps running.
  assign LED     = r_pattern & {N_LED{w_en}};
  assign KEY_EVT = w_key_evt;
  assign MODE    = r_mode;

endmodule

// File: tb/tb_led_pattern_ctrl.sv
// Testbench for led_pattern_ctrl.
// A reference model runs on every rising edge and queues the expected
// {LED, KEY_EVT, MODE}. A monitor on the falling edge pops the queue and
// compares. Directed checks against fixed values cover the main timing
// points of the design.
module tb_led_pattern_ctrl;

  localparam int CLK_HZ      = 1000;
  localparam int N_LED       = 8;
  localparam int DEBOUNCE_MS = 2;
  localparam int STEP_HZ     = 100;
  localparam int DB_CYC      = 2;
  localparam int STEP_CYC    = 10;

  // ---------------- clock / reset / DUT ----------------
  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] key;
  logic [3:0] sw;
  logic [7:0] led;
  logic [1:0] key_evt;
  logic [1:0] mode;

  always #5 clk = ~clk;

  led_pattern_ctrl #(
    .CLK_HZ     (CLK_HZ),
    .N_LED      (N_LED),
    .DEBOUNCE_MS(DEBOUNCE_MS),
    .STEP_HZ    (STEP_HZ)
  ) dut (
    .CLOCK_50(clk),
    .RST_N   (rst_n),
    .KEY     (key),
    .SW      (sw),
    .LED     (led),
    .KEY_EVT (key_evt),
    .MODE    (mode)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Raw inputs are delayed through a two-entry queue. Element [0] is the
  // value that the logic sees at this edge.
  logic [1:0]  m_key_q[$];
  logic [3:0]  m_sw_q[$];
  logic [1:0]  m_win[$];     // last DB_CYC+1 synchronised key samples
  logic [1:0]  m_stable;
  logic [1:0]  m_evt;
  logic [1:0]  m_mode;
  bit          m_paused;
  int          m_speed;
  int          m_wait;       // cycles spent in the current step period
  int          m_cnt_val;    // mode 0: counter value
  int          m_rot_pos;    // mode 1: index of the lit LED
  int          m_bnc_step;   // mode 2: steps taken along the triangle walk
  int          m_blk_cnt;    // mode 3: step parity
  logic [11:0] exp_q[$];

  task automatic model_reset();
    m_key_q = '{2'b11, 2'b11};
    m_sw_q  = '{4'b0000, 4'b0000};
    m_win.delete();
    m_stable   = 2'b11;
    m_evt      = 2'b00;
    m_mode     = 2'd0;
    m_paused   = 1'b0;
    m_speed    = 0;
    m_wait     = 0;
    m_cnt_val  = 0;
    m_rot_pos  = 0;
    m_bnc_step = 0;
    m_blk_cnt  = 0;
  endtask

  task automatic model_step();
    logic [1:0] k;
    logic [3:0] s;
    logic [1:0] ev_in;
    logic [1:0] new_evt;
    bit         all_diff;
    bit         step;
    int         period;
    k       = m_key_q[0];
    s       = m_sw_q[0];
    ev_in   = m_evt;
    new_evt = 2'b00;
    // A key's stable level follows the synchronised level only after a
    // full window of disagreeing samples. A press is a 1->0 change.
    m_win.push_back(k);
    if (m_win.size() > DB_CYC + 1) void'(m_win.pop_front());
    for (int i = 0; i < 2; i++) begin
      if (m_win.size() == DB_CYC + 1) begin
        all_diff = 1'b1;
        foreach (m_win[j]) if (m_win[j][i] == m_stable[i]) all_diff = 1'b0;
        if (all_diff) begin
          if (m_stable[i]) new_evt[i] = 1'b1;
          m_stable[i] = ~m_stable[i];
        end
      end
    end
    if (s[1:0] != m_mode) begin
      m_mode     = s[1:0];
      m_cnt_val  = 0;
      m_rot_pos  = 0;
      m_bnc_step = 0;
      m_blk_cnt  = 0;
      m_wait     = 0;
    end else begin
      period = STEP_CYC << m_speed;
      step   = !m_paused && (m_wait == period - 1);
      if (step) begin
        case (m_mode)
          2'd0:    m_cnt_val  = s[2] ? (m_cnt_val + 255) % 256 : (m_cnt_val + 1) % 256;
          2'd1:    m_rot_pos  = s[2] ? (m_rot_pos + N_LED - 1) % N_LED : (m_rot_pos + 1) % N_LED;
          2'd2:    m_bnc_step = (m_bnc_step + 1) % (2 * (N_LED - 1));
          default: m_blk_cnt  = m_blk_cnt ^ 1;
        endcase
      end
      if (ev_in[1] || step) m_wait = 0;
      else if (!m_paused)   m_wait = m_wait + 1;
    end
    m_paused = m_paused ^ ev_in[0];
    m_speed  = (m_speed + int'(ev_in[1])) % 4;
    m_key_q.push_back(key);
    void'(m_key_q.pop_front());
    m_sw_q.push_back(sw);
    void'(m_sw_q.pop_front());
    m_evt = new_evt;
  endtask

  function automatic logic [7:0] model_led();
    int         p;
    logic [7:0] pat;
    case (m_mode)
      2'd0: pat = 8'(m_cnt_val);
      2'd1: pat = 8'(1 << m_rot_pos);
      2'd2: begin
        p = m_bnc_step;
        if (p > N_LED - 1) p = 2 * (N_LED - 1) - p;
        pat = 8'(1 << p);
      end
      default: pat = (m_blk_cnt == 0) ? 8'hFF : 8'h00;
    endcase
    return m_sw_q[0][3] ? pat : 8'h00;
  endfunction

  always @(posedge clk) begin
    if (!rst_n) model_reset();
    else        model_step();
    exp_q.push_back({model_led(), m_evt, m_mode});
  end

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    logic [11:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("mon_led",     32'(led),     32'(e[11:4]));
      check("mon_key_evt", 32'(key_evt), 32'(e[3:2]));
      check("mon_mode",    32'(mode),    32'(e[1:0]));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press_key(input int idx, input int hold);
    key[idx] = 1'b0;
    idle(hold);
    key[idx] = 1'b1;
    idle(8);
  endtask

  task automatic glitch3();
    repeat (3) begin
      key[0] = 1'b0;
      @(negedge clk);
      key[0] = 1'b1;
      @(negedge clk);
    end
  endtask

  task automatic count_evt(input int n, input int idx, output int cnt);
    cnt = 0;
    repeat (n) begin
      @(negedge clk);
      if (key_evt[idx] === 1'b1) cnt++;
    end
  endtask

  task automatic count_led_changes(input int n, output int changes);
    logic [7:0] prev;
    changes = 0;
    prev    = led;
    repeat (n) begin
      @(negedge clk);
      if (led !== prev) changes++;
      prev = led;
    end
  endtask

  // Waits for one LED change, then returns the cycle count to the next.
  task automatic measure_interval(input string nm, input int exp_cyc);
    logic [7:0] prev;
    bit         seen;
    int         n;
    prev = led;
    seen = 1'b0;
    for (int i = 0; i < 400 && !seen; i++) begin
      @(negedge clk);
      if (led !== prev) seen = 1'b1;
    end
    prev = led;
    n    = 0;
    if (seen) begin
      seen = 1'b0;
      for (int i = 0; i < 400 && !seen; i++) begin
        @(negedge clk);
        n++;
        if (led !== prev) seen = 1'b1;
      end
    end
    if (!seen) n = -1;
    check(nm, n, exp_cyc);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int cnt;
    int first;
    rst_n = 1'b0;
    key   = 2'b11;
    sw    = 4'b1000;

    // Reset, then counter mode.
    idle(3);
    check("reset_led", led, 8'h00);
    check("reset_mode", mode, 2'd0);
    check("reset_evt", key_evt, 2'b00);
    rst_n = 1'b1;
    idle(9);
    check("pre_first_step", led, 8'h00);
    idle(1);
    check("first_step", led, 8'h01);
    idle(10);
    check("second_step", led, 8'h02);

    // Rotate, bounce, then reverse rotate.
    sw = 4'b1001;
    idle(3);
    check("rot_reload", led, 8'h01);
    check("rot_mode", mode, 2'd1);
    idle(10);
    check("rot_step", led, 8'h02);
    idle(90);
    sw = 4'b1010;
    idle(160);
    sw = 4'b1101;
    idle(3);
    check("rev_reload", led, 8'h01);
    idle(10);
    check("rev_step", led, 8'h80);
    idle(40);

    // Debounce: short glitches give no event.
    glitch3();
    count_evt(12, 0, cnt);
    check("glitch_evt", cnt, 0);

    // A long press gives one event, 5 cycles after the falling edge.
    key[0] = 1'b0;
    cnt    = 0;
    first  = -1;
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      if (key_evt[0] === 1'b1) begin
        cnt++;
        if (first < 0) first = i;
      end
      if (i == 10) key[0] = 1'b1;
    end
    check("press_evt_count", cnt, 1);
    check("press_evt_latency", first, 5);
    count_led_changes(30, cnt);
    check("paused_led_changes", cnt, 0);
    press_key(0, 6);
    idle(40);

    // Speed stepping.
    press_key(1, 8);
    measure_interval("speed1_interval", 20);
    press_key(1, 8);
    measure_interval("speed2_interval", 40);
    press_key(1, 8);
    measure_interval("speed3_interval", 80);
    press_key(1, 8);
    measure_interval("speed0_interval", 10);

    // LED enable off in blink mode, then back on.
    sw = 4'b0011;
    idle($urandom_range(23, 77));
    check("en_off_led", led, 8'h00);
    sw = 4'b1011;
    idle(20);

    // Reset during a debounce count.
    key[0] = 1'b0;
    idle(3);
    rst_n  = 1'b0;
    key[0] = 1'b1;
    idle(2);
    check("rst_mid_led", led, 8'h00);
    check("rst_mid_mode", mode, 2'd0);
    rst_n = 1'b1;
    count_evt(20, 0, cnt);
    check("rst_mid_no_evt", cnt, 0);

    // Reset while paused: stepping resumes after reset.
    press_key(0, 6);
    idle(10);
    rst_n = 1'b0;
    idle(2);
    check("rst_paused_evt", key_evt, 2'b00);
    rst_n = 1'b1;
    idle(12);
    check("rst_paused_blink_a", led, 8'hFF);
    idle(1);
    check("rst_paused_blink_b", led, 8'h00);

    // Mode change timed to land on a tick edge.
    rst_n = 1'b0;
    sw    = 4'b1000;
    idle(2);
    rst_n = 1'b1;
    idle(5);
    sw = 4'b1001;
    idle(3);
    check("tick_chg_rot_reload", led, 8'h01);
    idle(17);
    sw = 4'b1010;
    idle(3);
    check("tick_chg_reload", led, 8'h01);
    check("tick_chg_mode", mode, 2'd2);
    idle(9);
    check("tick_chg_hold", led, 8'h01);
    idle(1);
    check("tick_chg_next", led, 8'h02);

    // Randomised traffic against the model.
    for (int it = 0; it < 60; it++) begin
      case ($urandom_range(0, 9))
        0, 1: sw = 4'($urandom_range(0, 15));
        2, 3: press_key(int'($urandom_range(0, 1)), int'($urandom_range(1, 12)));
        4: begin
          key = 2'b00;
          idle($urandom_range(1, 10));
          key = 2'b11;
          idle(8);
        end
        5: glitch3();
        6: begin
          rst_n = 1'b0;
          idle($urandom_range(1, 3));
          rst_n = 1'b1;
        end
        default: idle($urandom_range(10, 90));
      endcase
      idle($urandom_range(0, 40));
    end
    key = 2'b11;
    idle(20);

    @(negedge clk);
    #2;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Watchdog: the run always ends, even if the stimulus stalls.
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/led_pattern_ctrl.md
# led_pattern_ctrl

Parametrised LED pattern engine for the DE0-Nano top level. It debounces the push-buttons, synchronises the slide switches, and drives the LED bank with one of four animated patterns. Pause/resume and speed stepping are controlled by the keys. It is instantiated directly under DE0_NANO, between the board pins (KEY, SW, LED) and nothing else, so the board has a self-test/demo function without a host connection.

## Interface
- CLK_HZ, 50_000_000: frequency of CLOCK_50 in Hz.
- N_LED, 8: LED count; legal range 2..32.
- DEBOUNCE_MS, 10: key debounce window in ms. DB_CYC = CLK_HZ/1000*DEBOUNCE_MS, minimum 1.
- STEP_HZ, 4: pattern step rate at speed 0. STEP_CYC = CLK_HZ/STEP_HZ, minimum 2.

- CLOCK_50, in, 1: single clock; all logic on the rising edge.
- RST_N, in, 1: reset, synchronous and active-low.
- KEY, in, 2: push-buttons, active-low (0 = pressed), asynchronous to the clock.
  - KEY[0]: pause/resume.
  - KEY[1]: speed step.
- SW, in, 4: slide switches, asynchronous to the clock.
  - SW[1:0]: mode.
  - SW[2]: reverse.
  - SW[3]: LED enable.
- LED, out, N_LED: LED drive, 1 = lit.
- KEY_EVT, out, 2: one-cycle press pulse per key, after debounce.
- MODE, out, 2: current synchronised mode.

## Operation
- **Input sync:** KEY and SW each pass through a 2-flop synchroniser. The synchroniser reset value is 1 for KEY and 0 for SW.
- **Debounce (per key):**
  - Each key keeps a stable level (reset 1) and a counter.
  - The counter increments while the synchronised level differs from the stable level. It clears as soon as the two are equal.
  - When the count reaches DB_CYC, the stable level takes the synchronised value and the counter clears.
  - A stable 1->0 transition produces KEY_EVT[i] = 1 for exactly one cycle. Releases produce no event.
- **Pause:** KEY_EVT[0] toggles `paused` (reset 0). While paused, the prescaler holds its value and no ticks occur.
- **Speed:**
  - KEY_EVT[1] advances `speed` 0->1->2->3->0 (reset 0) and clears the prescaler.
  - The tick period is STEP_CYC << speed cycles. Counter width must hold STEP_CYC*8-1.
- **Prescaler:** counts 0 .. (STEP_CYC<<speed)-1 when not paused. `tick` = 1 in the cycle the counter is at its terminal value; the counter then wraps to 0.
- **Mode change:**
  - When synchronised SW[1:0] differs from the registered MODE, MODE updates on that edge, the pattern loads the new mode's initial value, the prescaler clears, and bounce direction resets to left.
  - A mode change takes priority over a coincident tick.
- **Patterns:** the pattern register advances on each tick.
  - Mode 0, counter: initial value 0. Adds 1 per tick (subtracts 1 if SW[2]=1), modulo 2^N_LED.
  - Mode 1, rotate: initial value 1. Rotates left per tick (right if SW[2]=1).
  - Mode 2, bounce: initial value 1. Shifts left until bit N_LED-1 is set, then shifts right until bit 0 is set. The direction flips on the tick that reaches an end bit, so an end position is held for exactly one step. SW[2] is ignored.
  - Mode 3, blink: initial value all-ones. Inverts on each tick. SW[2] is ignored.
- **Output:** LED = pattern & {N_LED{en}}, where `en` is synchronised SW[3]. The pattern keeps advancing while LEDs are disabled.
- **Simultaneous events:**
  - Both key events in the same cycle: both take effect.
  - KEY_EVT[1] together with a tick: the tick advances the pattern and the prescaler clears.
  - KEY_EVT[0] together with a tick: the tick is honoured, then pause takes effect.
  - Pausing does not affect mode changes; these still reload the pattern.

## Timing
- **Reset:** RST_N low at an edge returns every register to its reset value on that edge, including mid-debounce and mid-pattern. Reset values: LED=0, KEY_EVT=0, MODE=0, pattern=0, prescaler=0, paused=0, speed=0, direction=left.
- **Key latency:** 2 cycles (sync) + DB_CYC cycles (debounce) + 1 cycle from a clean KEY edge to the KEY_EVT pulse.
- **Switch latency:** 2 sync cycles, then 1 cycle to update MODE and reload the pattern.
- **Pattern to LED:** the pattern updates on the edge where `tick`=1 and is visible on LED after that edge. There is no extra pipeline stage.
- **Step interval:** (STEP_CYC<<speed) cycles between pattern changes, exactly, while not paused.

## Test plan
Bench parameters: CLK_HZ=1000, DEBOUNCE_MS=2 (DB_CYC=2), STEP_HZ=100 (STEP_CYC=10), N_LED=8.

1. **Reset, counter mode:** hold RST_N=0 for 3 cycles with SW=4'b1000, then release.
   - LED=0 during reset.
   - After release, LED=8'h01 after 10 cycles and 8'h02 after 20 cycles.
2. **Rotate and bounce:**
   - SW=4'b1001: LED sequence 01,02,04,...,80,01 at 10-cycle steps.
   - SW=4'b1010: sequence 01,02,...,80,40,...,01,02.
   - SW=4'b1101 (mode 1, reverse): sequence 01,80,40,...
3. **Debounce:**
   - KEY[0] low for 1 cycle, 3 times with 1-cycle gaps: no KEY_EVT.
   - KEY[0] held low for 10 cycles: exactly one KEY_EVT[0] pulse, 5 cycles after the falling edge; LED then stops changing.
   - A second press resumes stepping from the held prescaler value.
4. **Speed:**
   - Three KEY[1] presses: step interval becomes 20, then 40, then 80 cycles.
   - A fourth press returns the interval to 10 cycles.
5. **Enable and reset mid-run:**
   - SW[3]=0 in mode 3: LED=0 while the internal pattern keeps toggling. Setting SW[3]=1 shows 00 or FF consistent with the elapsed tick count.
   - RST_N pulsed low during a debounce count or while paused: all state returns to its reset value, with no spurious KEY_EVT.
6. **Mode change coincident with tick:** change SW[1:0] timed so the reload lands on a tick edge. The pattern equals the new mode's initial value and the next step follows a full 10 cycles later.
